// File: rtl/sum_zero_triplets.sv
// Scans a fixed 16-entry signed table for index triplets i<j<k summing to zero,
// one combination per clock; hits stream out over a 4-phase valid/ack handshake.
module sum_zero_triplets #(
  parameter int MAX_N = 16,
  parameter int W     = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ack,
  input  logic [7:0]     size,
  output logic [3*W-1:0] tuple,
  output logic           valid
);

  localparam int AW = $clog2(MAX_N);
  localparam int IW = AW + 1;

  localparam logic [1:0] SEARCH   = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] WAIT_REL = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  // Entry 15 is leftmost, entry 0 rightmost.
  localparam logic [15:0][7:0] ROM = {
    8'h08, 8'hFA, 8'h07, 8'h06, 8'hFB, 8'h04, 8'hFD, 8'h05,
    8'hFE, 8'h03, 8'hFC, 8'hFF, 8'h02, 8'h01, 8'h00, 8'hFF
  };

  logic [1:0]    state;
  logic [IW-1:0] i, j, k, n;
  logic [IW-1:0] ni, nj, nk;
  logic [IW-1:0] n_in;
  logic          fin;
  logic          is_last;
  logic          hit;
  logic [W-1:0]  ai, aj, ak;
  logic [W+1:0]  sum;

  assign ai = ROM[i[AW-1:0]];
  assign aj = ROM[j[AW-1:0]];
  assign ak = ROM[k[AW-1:0]];

  // Two guard bits keep the three-way sum exact, so wrapped totals never alias to zero.
  assign sum = {{2{ai[W-1]}}, ai} + {{2{aj[W-1]}}, aj} + {{2{ak[W-1]}}, ak};
  assign hit = (sum == '0);

  assign n_in    = (size > 8'(MAX_N)) ? IW'(MAX_N) : IW'(size);
  assign is_last = (i == n - IW'(3)) && (j == n - IW'(2)) && (k == n - IW'(1));

  always_comb begin
    ni = i;
    nj = j;
    nk = k;
    if (k != n - IW'(1)) begin
      nk = k + IW'(1);
    end else if (j != n - IW'(2)) begin
      nj = j + IW'(1);
      nk = j + IW'(2);
    end else begin
      ni = i + IW'(1);
      nj = i + IW'(2);
      nk = i + IW'(3);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      tuple <= '0;
      i     <= IW'(0);
      j     <= IW'(1);
      k     <= IW'(2);
      n     <= n_in;
      fin   <= 1'b0;
      state <= (n_in < IW'(3)) ? DONE : SEARCH;
    end else begin
      case (state)
        SEARCH: begin
          // Indices freeze on the final combination so they never leave the table.
          if (!is_last) begin
            i <= ni;
            j <= nj;
            k <= nk;
          end
          if (hit) begin
            tuple <= {ak, aj, ai};
            valid <= 1'b1;
            fin   <= is_last;
            state <= WAIT_ACK;
          end else if (is_last) begin
            state <= DONE;
          end
        end
        WAIT_ACK: begin
          if (ack) begin
            valid <= 1'b0;
            state <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!ack) begin
            state <= fin ? DONE : SEARCH;
          end
        end
        default: begin
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_zero_triplets.sv
// Randomized bench for sum_zero_triplets against a brute-force triplet enumerator.
module tb_sum_zero_triplets;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ack = 1'b0;
  logic [7:0]  size = 8'd7;
  logic [23:0] tuple;
  logic        valid;

  int total = 0;
  int bad = 0;

  int rom_v[16] = '{-1, 0, 1, 2, -1, -4, 3, -2, 5, -3, 4, -5, 6, 7, -6, 8};
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];

  sum_zero_triplets dut (
    .clk(clk),
    .reset(reset),
    .ack(ack),
    .size(size),
    .tuple(tuple),
    .valid(valid)
  );

  always #5 clk = ~clk;

  // Every zero-sum triplet in index order, tuple packed as {a[k], a[j], a[i]}.
  function automatic void build_model(input int sz);
    int n;
    exp_q.delete();
    n = (sz > 16) ? 16 : sz;
    for (int a = 0; a < n; a++)
      for (int b = a + 1; b < n; b++)
        for (int c = b + 1; c < n; c++)
          if (rom_v[a] + rom_v[b] + rom_v[c] == 0)
            exp_q.push_back({8'(rom_v[c]), 8'(rom_v[b]), 8'(rom_v[a])});
  endfunction

  task automatic do_reset(input logic [7:0] sz, input int cyc);
    @(negedge clk);
    reset = 1'b1;
    size  = sz;
    ack   = 1'b0;
    repeat (cyc) @(negedge clk);
    reset = 1'b0;
  endtask

  // Acts as a consumer with random latencies; collects tuples into got_q.
  task automatic consume(input int cnt, output int tmo, output int viol);
    int w;
    logic [23:0] t;
    got_q.delete();
    tmo = 0;
    viol = 0;
    for (int r = 0; r < cnt && tmo == 0; r++) begin
      w = 0;
      while (valid !== 1'b1 && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (valid !== 1'b1) begin
        tmo++;
      end else begin
        t = tuple;
        got_q.push_back(t);
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          if (valid !== 1'b1 || tuple !== t) viol++;
        end
        ack = 1'b1;
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (valid !== 1'b0 && w < 50);
        if (valid !== 1'b0) tmo++;
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          if (valid !== 1'b0) viol++;
        end
        ack = 1'b0;
      end
    end
  endtask

  task automatic check_stream(input string name);
    int tmo, viol, hi;
    consume(exp_q.size(), tmo, viol);
    total++;
    if (tmo != 0 || got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s count: got %0d results (timeouts %0d), expected %0d", name, got_q.size(), tmo, exp_q.size());
    end
    for (int r = 0; r < got_q.size() && r < exp_q.size(); r++) begin
      total++;
      if (got_q[r] !== exp_q[r]) begin
        bad++;
        $display("FAIL %s result%0d: got %h expected %h", name, r, got_q[r], exp_q[r]);
      end
    end
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL %s handshake: %0d protocol violations, expected 0", name, viol);
    end
    hi = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid !== 1'b0) hi++;
    end
    total++;
    if (hi != 0) begin
      bad++;
      $display("FAIL %s done_idle: valid high %0d cycles, expected 0", name, hi);
    end
    if (exp_q.size() > 0) begin
      total++;
      if (tuple !== exp_q[exp_q.size()-1]) begin
        bad++;
        $display("FAIL %s done_tuple: got %h expected %h", name, tuple, exp_q[exp_q.size()-1]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    size = 8'd7;
    @(negedge clk);
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %b expected 0", valid);
    end
    total++;
    if (tuple !== 24'h0) begin
      bad++;
      $display("FAIL reset_tuple: got %h expected 000000", tuple);
    end
  endtask

  task automatic test_ack_tied_low();
    int changed;
    do_reset(8'd7, 2);
    @(negedge clk);
    total++;
    if (valid !== 1'b1 || tuple !== 24'h0100FF) begin
      bad++;
      $display("FAIL first_valid: got valid=%b tuple=%h expected 1 0100ff", valid, tuple);
    end
    changed = 0;
    repeat (25) begin
      @(negedge clk);
      if (valid !== 1'b1 || tuple !== 24'h0100FF) changed++;
    end
    total++;
    if (changed != 0) begin
      bad++;
      $display("FAIL hold_no_ack: %0d cycles changed, expected 0", changed);
    end
  endtask

  task automatic test_size7_sequence();
    logic [23:0] known[4] = '{24'h0100FF, 24'hFF02FF, 24'hFF0100, 24'h03FCFF};
    int tmo, viol;
    known[3] = 24'h03FC01;
    do_reset(8'd7, 2);
    consume(4, tmo, viol);
    for (int r = 0; r < 4; r++) begin
      total++;
      if (r >= got_q.size() || got_q[r] !== known[r]) begin
        bad++;
        $display("FAIL size7_result%0d: got %h expected %h", r, (r < got_q.size()) ? got_q[r] : 24'hx, known[r]);
      end
    end
    build_model(7);
    do_reset(8'd7, 2);
    check_stream("size7");
  endtask

  task automatic test_small_sizes();
    logic [7:0] szs[3] = '{8'd2, 8'd0, 8'd1};
    int hi;
    for (int s = 0; s < 3; s++) begin
      do_reset(szs[s], 2);
      hi = 0;
      repeat (100) begin
        @(negedge clk);
        if (valid !== 1'b0) hi++;
      end
      total++;
      if (hi != 0) begin
        bad++;
        $display("FAIL small_size%0d: valid high %0d cycles, expected 0", szs[s], hi);
      end
    end
  endtask

  task automatic test_reset_mid();
    int tmo, viol, w;
    do_reset(8'd7, 2);
    consume(1, tmo, viol);
    w = 0;
    while (valid !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (valid !== 1'b1 || tuple !== 24'hFF02FF) begin
      bad++;
      $display("FAIL mid_second: got valid=%b tuple=%h expected 1 ff02ff", valid, tuple);
    end
    reset = 1'b1;
    size = 8'd4;
    ack = 1'b1;
    @(negedge clk);
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_drop: got valid=%b expected 0", valid);
    end
    ack = 1'b0;
    reset = 1'b0;
    build_model(4);
    check_stream("restart4");
  endtask

  task automatic test_ack_held();
    int hi, w;
    build_model(7);
    do_reset(8'd7, 2);
    w = 0;
    while (valid !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    ack = 1'b1;
    hi = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid !== 1'b0) hi++;
    end
    total++;
    if (hi != 0) begin
      bad++;
      $display("FAIL ack_held: valid high %0d cycles while ack=1, expected 0", hi);
    end
    ack = 1'b0;
    w = 0;
    while (valid !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (valid !== 1'b1 || tuple !== exp_q[1]) begin
      bad++;
      $display("FAIL ack_release_next: got valid=%b tuple=%h expected 1 %h", valid, tuple, exp_q[1]);
    end
  endtask

  task automatic test_large();
    build_model(200);
    do_reset(8'd200, 2);
    check_stream("size200");
  endtask

  task automatic test_random_sizes();
    int sz;
    for (int it = 0; it < 5; it++) begin
      sz = $urandom_range(0, 24);
      build_model(sz);
      do_reset(8'(sz), $urandom_range(1, 3));
      check_stream($sformatf("rand_size%0d", sz));
    end
  endtask

  initial begin
    test_reset();
    test_ack_tied_low();
    test_size7_sequence();
    test_small_sizes();
    test_reset_mid();
    test_ack_held();
    test_large();
    test_random_sizes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
